// File: rtl/icache_axi_rd_bridge.sv
// Refill read bridge: turns one I-cache read request at a time into a single
// AXI4 read burst and hands the R beats back to the cache as registered pulses.
module icache_axi_rd_bridge #(
   parameter logic [3:0] AXI_ID     = 4'd0,
   parameter int         LINE_BEATS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [2:0]  rd_type,
   input  logic [31:0] rd_addr,
   output logic        rd_rdy,
   output logic        ret_valid,
   output logic        ret_last,
   output logic [63:0] ret_data,
   output logic        ret_err,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic        rvalid,
   output logic        rready,
   input  logic [63:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] AR   = 2'd1;
   localparam logic [1:0] R    = 2'd2;

   localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

   logic [1:0] state;
   logic [7:0] beat_cnt;
   logic       err_flag;
   logic       beat_last;
   logic       beat_err;

   // Handshake: an AR transfer happens on a cycle with arvalid && arready, an
   // R transfer on rvalid && rready; rd_req is only taken while rd_rdy is high.
   assign rd_rdy  = (state == IDLE);
   assign arid    = AXI_ID;
   assign arburst = 2'b01;

   // The last beat is decided by our own count; a disagreeing rlast is an error.
   always_comb begin
      beat_last = (beat_cnt == arlen);
      beat_err  = err_flag | (rresp != 2'b00) | (rlast != beat_last);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         ret_valid <= 1'b0;
         ret_last  <= 1'b0;
         ret_err   <= 1'b0;
         ret_data  <= 64'd0;
         araddr    <= 32'd0;
         arlen     <= 8'd0;
         arsize    <= 3'd0;
         beat_cnt  <= 8'd0;
         err_flag  <= 1'b0;
      end else begin
         ret_valid <= 1'b0;
         ret_last  <= 1'b0;
         ret_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_req) begin
                  arvalid <= 1'b1;
                  state   <= AR;
                  if (rd_type == 3'b100) begin
                     araddr <= {rd_addr[31:4], 4'b0000};
                     arlen  <= LINE_LEN;
                     arsize <= 3'd3;
                  end else begin
                     araddr <= rd_addr;
                     arlen  <= 8'd0;
                     // Reserved encodings fall back to a dword access.
                     arsize <= rd_type[2] ? 3'd3 : {1'b0, rd_type[1:0]};
                  end
               end
            end
            AR: begin
               if (arready) begin
                  arvalid  <= 1'b0;
                  rready   <= 1'b1;
                  beat_cnt <= 8'd0;
                  err_flag <= 1'b0;
                  state    <= R;
               end
            end
            R: begin
               if (rvalid) begin
                  ret_valid <= 1'b1;
                  ret_data  <= rdata;
                  beat_cnt  <= beat_cnt + 8'd1;
                  err_flag  <= beat_err;
                  if (beat_last) begin
                     ret_last <= 1'b1;
                     ret_err  <= beat_err;
                     rready   <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Bench for icache_axi_rd_bridge: directed vector table, hand sequences for
// reset/ignore corners, and randomized transactions against a spec-level model.
module tb_icache_axi_rd_bridge;

   localparam int LINE_BEATS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_req;
   logic [2:0]  rd_type;
   logic [31:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [63:0] ret_data;
   logic        ret_err;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   icache_axi_rd_bridge #(.AXI_ID(4'd0), .LINE_BEATS(LINE_BEATS)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .ret_err(ret_err),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int ar_hs_cnt = 0;

   // Expected return beats: {data, last, err}
   logic [65:0] exp_q[$];
   logic [65:0] mon_e;

   logic [63:0] bd[LINE_BEATS];
   logic [1:0]  br[LINE_BEATS];
   logic        bl[LINE_BEATS];

   typedef struct {
      logic [2:0]  t;
      logic [31:0] a;
      int          ar_dly;
      int          gap;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  r0;
      logic [1:0]  r1;
      logic        l0;
      logic        l1;
      logic [31:0] e_addr;
      logic [7:0]  e_len;
      logic [2:0]  e_size;
      logic        e_err;
   } vec_t;

   vec_t tbl[12];

   logic [2:0]  m_t;
   logic [31:0] m_a;
   logic [31:0] m_addr;
   logic [7:0]  m_len;
   logic [2:0]  m_size;
   logic        m_err;
   int          m_n;
   int          idle;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: count AR handshakes, score every returned beat in order.
   always @(negedge clk) begin
      if (rst) begin
         if (arvalid && arready) ar_hs_cnt++;
         if (ret_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL ret_unexpected actual=%0h_%0b_%0b expected=none at %0t",
                        ret_data, ret_last, ret_err, $time);
            end else begin
               mon_e = exp_q.pop_front();
               if ({ret_data, ret_last, ret_err} !== mon_e) begin
                  failures++;
                  $display("FAIL ret_beat actual=%0h_%0b_%0b expected=%0h_%0b_%0b at %0t",
                           ret_data, ret_last, ret_err, mon_e[65:2], mon_e[1], mon_e[0], $time);
               end
            end
         end else if (ret_last || ret_err) begin
            checks++;
            failures++;
            $display("FAIL ret_stray_pulse actual=last%0b_err%0b expected=0_0 at %0t",
                     ret_last, ret_err, $time);
         end
      end
   end

   // Spec-level model of the AR fields for a request.
   function automatic void model_ar(input logic [2:0] t, input logic [31:0] a,
                                    output logic [31:0] ea, output logic [7:0] el,
                                    output logic [2:0] es);
      if (t == 3'd4) begin
         ea = a - (a % 32'd16);
         el = 8'(LINE_BEATS - 1);
         es = 3'd3;
      end else if (t > 3'd4) begin
         ea = a;
         el = 8'd0;
         es = 3'd3;
      end else begin
         ea = a;
         el = 8'd0;
         es = t;
      end
   endfunction

   task automatic txn(input logic [2:0] t, input logic [31:0] a, input int ar_dly, input int gap,
                      input logic [31:0] e_addr, input logic [7:0] e_len, input logic [2:0] e_size,
                      input logic e_err, input bit b2b, input int abort_after);
      int   n;
      int   hs0;
      logic lastb;
      n = int'(e_len) + 1;
      for (int i = 0; i < n; i++) begin
         lastb = (i == n - 1);
         exp_q.push_back({bd[i], lastb, lastb & e_err});
      end
      rd_req = 1'b1; rd_type = t; rd_addr = a;
      @(negedge clk);
      chk("rd_rdy_idle", rd_rdy, 1'b1);
      chk("arvalid_idle", arvalid, 1'b0);
      chk("rready_idle", rready, 1'b0);
      if (b2b) chk("ret_last_b2b", ret_last, 1'b1);
      @(posedge clk); #1;
      rd_req = 1'b0; rd_type = 3'($urandom); rd_addr = $urandom;
      hs0 = ar_hs_cnt;
      for (int k = 0; k <= ar_dly; k++) begin
         arready = (k == ar_dly);
         @(negedge clk);
         chk("arvalid_held", arvalid, 1'b1);
         chk("araddr", araddr, e_addr);
         chk("arlen", arlen, e_len);
         chk("arsize", arsize, e_size);
         chk("arid", arid, 4'd0);
         chk("arburst", arburst, 2'b01);
         chk("rd_rdy_busy", rd_rdy, 1'b0);
         chk("rready_in_ar", rready, 1'b0);
         @(posedge clk); #1;
      end
      arready = 1'b0;
      chk("ar_handshakes", 64'(ar_hs_cnt - hs0), 64'd1);
      for (int b = 0; b < n; b++) begin
         repeat (gap) begin
            rvalid = 1'b0;
            @(negedge clk);
            chk("rready_gap", rready, 1'b1);
            @(posedge clk); #1;
         end
         rvalid = 1'b1; rdata = bd[b]; rresp = br[b]; rlast = bl[b];
         @(negedge clk);
         chk("rready_beat", rready, 1'b1);
         chk("arvalid_in_r", arvalid, 1'b0);
         @(posedge clk); #1;
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = {$urandom, $urandom};
         if (b == abort_after) begin
            @(negedge clk); #1;
            rst = 1'b0;
            #1;
            chk("rst_rd_rdy", rd_rdy, 1'b1);
            chk("rst_rready", rready, 1'b0);
            chk("rst_arvalid", arvalid, 1'b0);
            chk("rst_ret_valid", ret_valid, 1'b0);
            chk("rst_ret_last", ret_last, 1'b0);
            chk("rst_ret_data", ret_data, 64'd0);
            chk("rst_araddr", araddr, 32'd0);
            exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
      arready = 1'b0; rvalid = 1'b0; rdata = 64'd0; rresp = 2'b00; rlast = 1'b0;

      tbl[0]  = '{3'd4, 32'h8000_0128, 0, 0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                  2'b00, 2'b00, 1'b0, 1'b1, 32'h8000_0120, 8'd1, 3'd3, 1'b0};
      tbl[1]  = '{3'd4, 32'h1234_567C, 5, 0, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                  2'b00, 2'b00, 1'b0, 1'b1, 32'h1234_5670, 8'd1, 3'd3, 1'b0};
      tbl[2]  = '{3'd2, 32'h8000_0004, 0, 0, 64'h0000_0000_DEAD_BEEF, 64'd0,
                  2'b00, 2'b00, 1'b1, 1'b0, 32'h8000_0004, 8'd0, 3'd2, 1'b0};
      tbl[3]  = '{3'd4, 32'h8000_0200, 1, 0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  2'b10, 2'b00, 1'b0, 1'b1, 32'h8000_0200, 8'd1, 3'd3, 1'b1};
      tbl[4]  = '{3'd4, 32'h8000_0310, 0, 1, 64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020,
                  2'b00, 2'b00, 1'b1, 1'b1, 32'h8000_0310, 8'd1, 3'd3, 1'b1};
      tbl[5]  = '{3'd4, 32'h8000_040F, 0, 3, 64'h3030_3030_3030_3030, 64'h4040_4040_4040_4040,
                  2'b00, 2'b00, 1'b0, 1'b1, 32'h8000_0400, 8'd1, 3'd3, 1'b0};
      tbl[6]  = '{3'd0, 32'h0000_0003, 0, 0, 64'h0000_0000_0000_00A5, 64'd0,
                  2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_0003, 8'd0, 3'd0, 1'b0};
      tbl[7]  = '{3'd1, 32'h0000_0106, 2, 1, 64'h0000_0000_0000_5A5A, 64'd0,
                  2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_0106, 8'd0, 3'd1, 1'b0};
      tbl[8]  = '{3'd3, 32'h0000_0008, 0, 0, 64'hCAFE_F00D_1234_5678, 64'd0,
                  2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_0008, 8'd0, 3'd3, 1'b0};
      tbl[9]  = '{3'd7, 32'h8000_0129, 0, 0, 64'h7777_7777_7777_7777, 64'd0,
                  2'b00, 2'b00, 1'b1, 1'b0, 32'h8000_0129, 8'd0, 3'd3, 1'b0};
      tbl[10] = '{3'd2, 32'h8000_0020, 0, 0, 64'h0000_0000_1357_9BDF, 64'd0,
                  2'b00, 2'b00, 1'b0, 1'b0, 32'h8000_0020, 8'd0, 3'd2, 1'b1};
      tbl[11] = '{3'd3, 32'h8000_0030, 1, 2, 64'h2468_ACE0_2468_ACE0, 64'd0,
                  2'b11, 2'b00, 1'b1, 1'b0, 32'h8000_0030, 8'd0, 3'd3, 1'b1};

      // Reset values, sampled while reset is held.
      @(negedge clk);
      chk("reset_rd_rdy", rd_rdy, 1'b1);
      chk("reset_arvalid", arvalid, 1'b0);
      chk("reset_rready", rready, 1'b0);
      chk("reset_ret_valid", ret_valid, 1'b0);
      chk("reset_ret_last", ret_last, 1'b0);
      chk("reset_ret_err", ret_err, 1'b0);
      chk("reset_ret_data", ret_data, 64'd0);
      chk("reset_araddr", araddr, 32'd0);
      chk("reset_arlen", arlen, 8'd0);
      chk("reset_arsize", arsize, 3'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed table, issued back-to-back on each ret_last cycle.
      for (int i = 0; i < 12; i++) begin
         bd[0] = tbl[i].d0; bd[1] = tbl[i].d1;
         br[0] = tbl[i].r0; br[1] = tbl[i].r1;
         bl[0] = tbl[i].l0; bl[1] = tbl[i].l1;
         txn(tbl[i].t, tbl[i].a, tbl[i].ar_dly, tbl[i].gap, tbl[i].e_addr, tbl[i].e_len,
             tbl[i].e_size, tbl[i].e_err, (i > 0), -1);
      end

      // R beats offered while idle must be ignored.
      repeat (4) begin
         rvalid = 1'b1; rdata = {$urandom, $urandom}; rlast = 1'b1;
         @(negedge clk);
         chk("rready_idle_junk", rready, 1'b0);
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0;
      @(negedge clk);
      chk("drain_after_table", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;

      // Reset after the first beat of a line, then a normal word read.
      bd[0] = 64'h9999_0000_9999_0000; bd[1] = 64'h8888_0000_8888_0000;
      br[0] = 2'b00; br[1] = 2'b00; bl[0] = 1'b0; bl[1] = 1'b1;
      txn(3'd4, 32'h8000_0500, 0, 0, 32'h8000_0500, 8'd1, 3'd3, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      bd[0] = 64'h0000_0000_C0DE_0001; br[0] = 2'b00; bl[0] = 1'b1;
      txn(3'd2, 32'h8000_0604, 0, 0, 32'h8000_0604, 8'd0, 3'd2, 1'b0, 1'b0, -1);

      // Randomized transactions against the model.
      for (int j = 0; j < 40; j++) begin
         idle = $urandom_range(0, 2);
         repeat (idle) begin
            rvalid = 1'($urandom); rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("rready_idle_rand", rready, 1'b0);
            @(posedge clk); #1;
         end
         rvalid = 1'b0;
         m_t = 3'($urandom_range(0, 7));
         m_a = $urandom;
         model_ar(m_t, m_a, m_addr, m_len, m_size);
         m_n = int'(m_len) + 1;
         m_err = 1'b0;
         for (int i = 0; i < LINE_BEATS; i++) begin
            bd[i] = {$urandom, $urandom};
            br[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bl[i] = (i == m_n - 1);
            if ($urandom_range(0, 7) == 0) bl[i] = ~bl[i];
            if (i < m_n && (br[i] != 2'b00 || bl[i] != (i == m_n - 1))) m_err = 1'b1;
         end
         txn(m_t, m_a, $urandom_range(0, 3), $urandom_range(0, 2), m_addr, m_len, m_size, m_err,
             (idle == 0), -1);
      end

      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("final_drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
